// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, sequencer state encoding and the queued command record
package alu_pkg;
    localparam int W    = 4;
    localparam int OPW  = 3;
    localparam int TAGW = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [OPW-1:0]  opn;
        logic [TAGW-1:0] tag;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, extra pointer bit tells full from empty
module alu_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = alu_pkg::cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        do_push, do_pop;
    T            mem_q [DEPTH];
    T            mem_d [DEPTH];
    assign empty   = wr_q == rd_q;
    assign full    = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + PW'(do_push);
        rd_d = rd_q + PW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: buffers tagged ALU commands, issues them, waits LAT edges and holds the result
module alu_seq #(
    parameter int W     = alu_pkg::W,
    parameter int OPW   = alu_pkg::OPW,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic [OPW-1:0] cmd_opn,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_opn,
    input  logic [W-1:0]   alu_out0,
    input  logic [W-1:0]   alu_out1,
    input  logic [W-1:0]   alu_status,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_out0,
    output logic [W-1:0]   res_out1,
    output logic [W-1:0]   res_status,
    output logic [3:0]     res_tag,
    output logic           busy
);
    import alu_pkg::*;
    localparam int CW = LAT > 0 ? $clog2(LAT + 1) : 1;
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     tag_q, tag_d, cur_tag_q, cur_tag_d;
    logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_opn_q, alu_opn_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_out0_q, res_out0_d, res_out1_q, res_out1_d, res_status_q, res_status_d;
    logic [3:0]     res_tag_q, res_tag_d;
    logic           full, empty, push, pop;
    cmd_t           wr_cmd, head;
    assign cmd_ready = !full && rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == IDLE && !empty;
    assign busy      = state_q != IDLE || !empty;
    assign wr_cmd    = '{a: cmd_a, b: cmd_b, opn: cmd_opn, tag: tag_q};
    alu_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (wr_cmd),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    always_comb begin
        tag_d        = tag_q + 4'(push);
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_tag_d    = cur_tag_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opn_d    = alu_opn_q;
        res_valid_d  = res_valid_q;
        res_out0_d   = res_out0_q;
        res_out1_d   = res_out1_q;
        res_status_d = res_status_q;
        res_tag_d    = res_tag_q;
        case (state_q)
            IDLE: if (pop) begin
                alu_a_d   = head.a;
                alu_b_d   = head.b;
                alu_opn_d = head.opn;
                cur_tag_d = head.tag;
                cnt_d     = CW'(LAT);
                state_d   = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                res_out0_d   = alu_out0;
                res_out1_d   = alu_out1;
                res_status_d = alu_status;
                res_tag_d    = cur_tag_q;
                res_valid_d  = 1'b1;
                state_d      = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            cur_tag_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opn_q    <= '0;
            res_valid_q  <= 1'b0;
            res_out0_q   <= '0;
            res_out1_q   <= '0;
            res_status_q <= '0;
            res_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            cur_tag_q    <= cur_tag_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opn_q    <= alu_opn_d;
            res_valid_q  <= res_valid_d;
            res_out0_q   <= res_out0_d;
            res_out1_q   <= res_out1_d;
            res_status_q <= res_status_d;
            res_tag_q    <= res_tag_d;
        end
    end
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opn    = alu_opn_q;
    assign res_valid  = res_valid_q;
    assign res_out0   = res_out0_q;
    assign res_out1   = res_out1_q;
    assign res_status = res_status_q;
    assign res_tag    = res_tag_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq driving a one-cycle registered ALU stub
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_opn = '0;
    logic [3:0] alu_a, alu_b, alu_out0, alu_out1, alu_status;
    logic [2:0] alu_opn;
    logic       res_valid, res_ready = 1'b0, busy;
    logic [3:0] res_out0, res_out1, res_status, res_tag;
    int         n_chk = 0, n_pass = 0;
    logic [3:0] tb_tag = '0, last_tag = 4'hf;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq #(.W(4), .OPW(3), .LAT(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opn(cmd_opn),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opn(alu_opn),
        .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_status(alu_status),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out0(res_out0), .res_out1(res_out1), .res_status(res_status),
        .res_tag(res_tag), .busy(busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out0   <= '0;
            alu_out1   <= '0;
            alu_status <= '0;
        end else begin
            alu_out0   <= alu_a;
            alu_out1   <= alu_b;
            alu_status <= {1'b0, alu_opn};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // result is consumed at the next posedge, so one compare per handshake
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got %0h expected none",
                         {res_out0, res_out1, res_status, res_tag});
            end else begin
                chk("result", {res_out0, res_out1, res_status, res_tag}, exp_q.pop_front());
            end
            last_tag = res_tag;
        end
    end

    task automatic apply_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_q.delete();
        tb_tag = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_opn = o;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
        exp_q.push_back({a, b, 1'b0, o, tb_tag});
        tb_tag++;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        res_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // reset values
        tick();
        tick();
        chk("reset_outputs", {2'b0, cmd_ready, alu_a, alu_b, alu_opn, res_valid,
            res_out0, res_out1, res_status, res_tag, busy}, 32'd0);
        rst = 1'b1;
        tick();
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("idle_not_busy", 32'(busy), 32'd0);

        // single command timing
        send(4'd3, 4'd7, 3'd0);
        tick();
        chk("alu_drive_edge1", {alu_a, alu_b, alu_opn}, {4'd3, 4'd7, 3'd0});
        chk("no_result_edge1", 32'(res_valid), 32'd0);
        tick();
        chk("no_result_edge2", 32'(res_valid), 32'd0);
        chk("busy_in_wait", 32'(busy), 32'd1);
        tick();
        chk("result_edge3", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("consumed_valid", 32'(res_valid), 32'd0);
        chk("idle_again", 32'(busy), 32'd0);

        // backpressure fills one in flight plus four queued
        apply_reset();
        send(4'd4, 4'd5, 3'd3);
        send(4'd1, 4'd2, 3'd1);
        send(4'd6, 4'd8, 3'd2);
        send(4'd9, 4'd10, 3'd5);
        send(4'd11, 4'd12, 3'd7);
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        repeat (4) tick();
        chk("held_valid", 32'(res_valid), 32'd1);
        chk("held_result", {res_out0, res_out1, res_status, res_tag}, {4'd4, 4'd5, 4'd3, 4'd0});
        chk("held_alu_drive", {alu_a, alu_b, alu_opn}, {4'd4, 4'd5, 3'd3});
        drain("drain_backpressure");

        // tag wrap over 17 commands
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(4'(i), 4'(15 - i), 3'(i));
        drain("drain_wrap");
        chk("wrap_last_tag", 32'(last_tag), 32'd0);

        // reset during WAIT with two queued
        apply_reset();
        send(4'd1, 4'd1, 3'd1);
        send(4'd2, 4'd2, 3'd2);
        send(4'd3, 4'd3, 3'd3);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        tb_tag = '0;
        #1;
        chk("mid_reset_ready", 32'(cmd_ready), 32'd0);
        chk("mid_reset_valid", 32'(res_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_reset_valid", 32'(res_valid), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        res_ready = 1'b1;
        repeat (5) tick();
        send(4'd9, 4'd9, 3'd5);
        drain("drain_after_reset");
        chk("post_reset_tag", 32'(last_tag), 32'd0);

        // push while IDLE pops with three queued
        apply_reset();
        send(4'd1, 4'd2, 3'd0);
        send(4'd3, 4'd4, 3'd1);
        send(4'd5, 4'd6, 3'd2);
        send(4'd7, 4'd8, 3'd3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        send(4'd9, 4'd10, 3'd4);
        chk("pushpop_ready", 32'(cmd_ready), 32'd1);
        send(4'd11, 4'd12, 3'd5);
        chk("pushpop_count", 32'(cmd_ready), 32'd0);
        drain("drain_pushpop");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
